spi_slave_uc: RTL

SPI slave receiver for the MBED link: the FPGA acts as the SPI slave so the microcontroller can push 16-bit command/config words into the design. It is the counterpart to the existing SPI master, which streams FIFO data out to the MBED. The block oversamples SCK, CSbar and MOSI in the SYS_CLK domain and deserialises MSB-first words. It presents each word on a valid/ready handshake and simultaneously shifts a status word back on MISO.

---
 rtl/spi_slave_uc_pkg.sv | 11 +
 rtl/spi_slave_uc_sync_edge.sv | 35 +++
 rtl/spi_slave_uc.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_slave_uc_pkg.sv
// rtl/spi_slave_uc_pkg.sv - shared constants and FSM encoding for the MBED SPI link
package spi_slave_uc_pkg;

  // Word length shared with the SPI master side of the link.
  localparam int SPI_WORD_BITS = 16;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;

endpackage

// File: rtl/spi_slave_uc_sync_edge.sv
// rtl/spi_slave_uc_sync_edge.sv - pad synchroniser with history flop and edge strobes
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_uc.sv
// rtl/spi_slave_uc.sv - oversampled SPI mode-0 slave: MOSI words out on valid/ready, status word on MISO
module spi_slave_uc
  import spi_slave_uc_pkg::*;
#(
  parameter int inBits      = SPI_WORD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SYS_CLK,
  input  logic              reset,
  input  logic              SCK,
  input  logic              CSbar,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [inBits-1:0] DATA_MISO,
  output logic [inBits-1:0] DATA_MOSI,
  output logic              VALID,
  input  logic              READY,
  output logic              BUSY,
  output logic              OVF,
  output logic              FRAME_ERR
);

  localparam int CW = $clog2(inBits + 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic sck_lvl_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(SYS_CLK), .rst_n(reset), .d(SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(SYS_CLK), .rst_n(reset), .d(CSbar),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(SYS_CLK), .rst_n(reset), .d(MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  assign sck_lvl_unused = sck_lvl;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [inBits-1:0] rx_q, rx_d, tx_q, tx_d, data_q, data_d, word;
  logic              valid_q, valid_d, ovf_q, ovf_d, fe_q, fe_d, word_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    fe_d      = 1'b0;
    word_done = 1'b0;
    word      = {rx_q[inBits-2:0], mosi_lvl};
    cnt_inc   = cnt_q + CW'(1);
    case (state_q)
      ST_WAIT_IDLE: if (cs_lvl) state_d = ST_IDLE;
      ST_IDLE: begin
        if (cs_fall) begin
          tx_d    = DATA_MISO;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Chip-select edge wins over any SCK edge in the same cycle.
        if (cs_rise) begin
          state_d = ST_IDLE;
          fe_d    = (cnt_q != '0);
        end else if (sck_rise) begin
          rx_d = word;
          if (cnt_inc == CW'(inBits)) begin
            word_done = 1'b1;
            cnt_d     = '0;
            tx_d      = DATA_MISO;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (sck_fall && cnt_q != '0) begin
          // A zero count means a freshly loaded word: keep its MSB on MISO.
          tx_d = {tx_q[inBits-2:0], 1'b0};
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase

    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (word_done && (!valid_q || READY)) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (word_done) begin
      ovf_d = 1'b1;
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      fe_q    <= fe_d;
    end
  end

  assign MISO      = (state_q == ST_SHIFT) ? tx_q[inBits-1] : 1'b0;
  assign DATA_MOSI = data_q;
  assign VALID     = valid_q;
  assign OVF       = ovf_q;
  assign FRAME_ERR = fe_q;
  assign BUSY      = ~cs_lvl & (state_q != ST_WAIT_IDLE);

endmodule
